// File: rtl/div_float.sv
// Sequential IEEE-754 divider (binary64 or binary32): restoring radix-2 iteration,
// single-step normalise/round, registered result and status flags with a done pulse.
module div_float #(
  parameter int FLOAT_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [FLOAT_WIDTH-1:0] op1,
  input  logic [FLOAT_WIDTH-1:0] op2,
  output logic [FLOAT_WIDTH-1:0] out_reg,
  output logic                   nan_reg,
  output logic                   overflow_reg,
  output logic                   underflow_reg,
  output logic                   zero_reg,
  output logic                   div_by_zero_reg,
  output logic                   done_reg
);
  localparam int EXP_WIDTH      = (FLOAT_WIDTH == 64) ? 11 : 8;
  localparam int FRACTION_WIDTH = (FLOAT_WIDTH == 64) ? 52 : 23;
  localparam int DW  = 1 + EXP_WIDTH + FRACTION_WIDTH;
  localparam int QW  = FRACTION_WIDTH + 3;
  localparam int EW2 = EXP_WIDTH + 2;
  localparam int FW  = FRACTION_WIDTH;

  localparam logic [EW2-1:0]        BIAS    = EW2'((1 << (EXP_WIDTH - 1)) - 1);
  localparam logic signed [EW2-1:0] EMAX    = EW2'((1 << EXP_WIDTH) - 1);
  localparam logic [DW-1:0]         NAN_PAT = (FLOAT_WIDTH == 64) ? DW'(64'h7FF8_0000_0000_0000)
                                                                  : DW'(32'hFFC0_0000);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] ITER  = 3'd2;
  localparam logic [2:0] NORM  = 3'd3;
  localparam logic [2:0] OUT   = 3'd4;

  logic [2:0]            state;
  logic [5:0]            cnt;
  logic [DW-1:0]         a_reg, b_reg;
  logic [FW:0]           m2;
  logic [FW+2:0]         rem;
  logic [QW-1:0]         q;
  logic signed [EW2-1:0] e;
  logic [FW-1:0]         frac;

  // Operand field decode
  logic                 s1, s2, sign;
  logic [EXP_WIDTH-1:0] x1, x2;
  logic [FW-1:0]        f1, f2;
  logic                 nan1, nan2, inf1, inf2, zero1, zero2;

  assign s1    = a_reg[DW-1];
  assign s2    = b_reg[DW-1];
  assign x1    = a_reg[DW-2 -: EXP_WIDTH];
  assign x2    = b_reg[DW-2 -: EXP_WIDTH];
  assign f1    = a_reg[FW-1:0];
  assign f2    = b_reg[FW-1:0];
  assign sign  = s1 ^ s2;
  assign nan1  = (&x1) & (|f1);
  assign nan2  = (&x2) & (|f2);
  assign inf1  = (&x1) & ~(|f1);
  assign inf2  = (&x2) & ~(|f2);
  assign zero1 = ~(|x1);
  assign zero2 = ~(|x2);

  // One restoring-division step
  logic          ge;
  logic [FW+2:0] rem_sub;
  assign ge      = rem >= {2'b00, m2};
  assign rem_sub = ge ? rem - {2'b00, m2} : rem;

  // Normalise and round (guard bit added, so ties go away from zero)
  logic [QW-1:0]         qn;
  logic [FW+1:0]         rounded;
  logic signed [EW2-1:0] e_adj, e_norm;
  assign qn      = q[QW-1] ? q : {q[QW-2:0], 1'b0};
  assign rounded = {1'b0, qn[QW-1:2]} + (FW+2)'(qn[1]);
  assign e_adj   = q[QW-1] ? e : e - EW2'(1);
  assign e_norm  = rounded[FW+1] ? e_adj + EW2'(1) : e_adj;

  // Final result selection, highest-priority special case first
  logic [DW-1:0] res;
  logic [4:0]    flags;  // {nan, overflow, underflow, zero, div_by_zero}
  always_comb begin
    res   = {sign, e[EXP_WIDTH-1:0], frac};
    flags = 5'b00000;
    if (nan1 || nan2 || (zero1 && zero2) || (inf1 && inf2)) begin
      res   = NAN_PAT;
      flags = 5'b10000;
    end else if (zero2 && !inf1) begin
      res   = {sign, {EXP_WIDTH{1'b1}}, {FW{1'b0}}};
      flags = 5'b00001;
    end else if (inf1) begin
      res   = {sign, {EXP_WIDTH{1'b1}}, {FW{1'b0}}};
    end else if (zero1 || inf2) begin
      res   = {sign, {(DW-1){1'b0}}};
      flags = 5'b00010;
    end else if (e >= EMAX) begin
      res   = {sign, {EXP_WIDTH{1'b1}}, {FW{1'b0}}};
      flags = 5'b01000;
    end else if (e <= 0) begin
      res   = {sign, {(DW-1){1'b0}}};
      flags = 5'b00110;
    end
  end

  // Control and architecturally visible outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      out_reg         <= '0;
      nan_reg         <= 1'b0;
      overflow_reg    <= 1'b0;
      underflow_reg   <= 1'b0;
      zero_reg        <= 1'b0;
      div_by_zero_reg <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values.
      done_reg <= 1'b0;
      if (start) begin
        state <= SETUP;
      end else begin
        case (state)
          SETUP: begin
            cnt   <= '0;
            state <= ITER;
          end
          ITER: begin
            cnt <= cnt + 6'd1;
            if (cnt == 6'(QW - 1)) state <= NORM;
          end
          NORM: state <= OUT;
          OUT: begin
            out_reg <= FLOAT_WIDTH'(res);
            {nan_reg, overflow_reg, underflow_reg, zero_reg, div_by_zero_reg} <= flags;
            done_reg <= 1'b1;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // NOTE: datapath registers carry no reset; the control FSM guarantees they are
  // rewritten (capture, then SETUP) before any result is produced from them.
  always_ff @(posedge clk) begin
    if (start) begin
      a_reg <= op1[DW-1:0];
      b_reg <= op2[DW-1:0];
    end
    case (state)
      SETUP: begin
        m2  <= {1'b1, f2};
        rem <= {2'b00, 1'b1, f1};
        q   <= '0;
        e   <= EW2'({2'b00, x1}) - EW2'({2'b00, x2}) + BIAS;
      end
      ITER: begin
        q   <= {q[QW-2:0], ge};
        rem <= {rem_sub[FW+1:0], 1'b0};
      end
      NORM: begin
        e    <= e_norm;
        frac <= rounded[FW-1:0];
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_div_float.sv
// Scoreboard bench for div_float: directed vectors on a binary64 and a binary32
// instance; a monitor pops expected results whenever done_reg is seen.
module tb_div_float;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start64, start32;
  logic [63:0] op1_64, op2_64, out64;
  logic [31:0] op1_32, op2_32, out32;
  logic        nan64, ovf64, unf64, zero64, dbz64, done64;
  logic        nan32, ovf32, unf32, zero32, dbz32, done32;

  always #5 clk = ~clk;

  div_float #(.FLOAT_WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .start(start64), .op1(op1_64), .op2(op2_64),
    .out_reg(out64), .nan_reg(nan64), .overflow_reg(ovf64), .underflow_reg(unf64),
    .zero_reg(zero64), .div_by_zero_reg(dbz64), .done_reg(done64)
  );

  div_float #(.FLOAT_WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .op1(op1_32), .op2(op2_32),
    .out_reg(out32), .nan_reg(nan32), .overflow_reg(ovf32), .underflow_reg(unf32),
    .zero_reg(zero32), .div_by_zero_reg(dbz32), .done_reg(done32)
  );

  localparam logic [4:0] F_NONE = 5'b00000;
  localparam logic [4:0] F_NAN  = 5'b10000;
  localparam logic [4:0] F_OVF  = 5'b01000;
  localparam logic [4:0] F_UNFZ = 5'b00110;
  localparam logic [4:0] F_ZERO = 5'b00010;
  localparam logic [4:0] F_DBZ  = 5'b00001;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  flags;
    int          edge_n;
    int          id;
  } exp_t;

  exp_t q64[$];
  exp_t q32[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every done pulse against the oldest expected entry
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done64) begin
      if (q64.size() == 0) check("spurious_done64", 64'(done64), 64'd0);
      else begin
        e = q64.pop_front();
        check($sformatf("res64_%0d", e.id), out64, e.res);
        check($sformatf("flags64_%0d", e.id), 64'({nan64, ovf64, unf64, zero64, dbz64}), 64'(e.flags));
        check($sformatf("latency64_%0d", e.id), 64'(cyc), 64'(e.edge_n));
      end
    end
    if (rst_n && done32) begin
      if (q32.size() == 0) check("spurious_done32", 64'(done32), 64'd0);
      else begin
        e = q32.pop_front();
        check($sformatf("res32_%0d", e.id), 64'(out32), e.res);
        check($sformatf("flags32_%0d", e.id), 64'({nan32, ovf32, unf32, zero32, dbz32}), 64'(e.flags));
        check($sformatf("latency32_%0d", e.id), 64'(cyc), 64'(e.edge_n));
      end
    end
  end

  // The edge sampling start is cyc+1; done is seen FRACTION_WIDTH+6 edges later
  task automatic issue64(input logic [63:0] a, input logic [63:0] b, input logic [63:0] r,
                         input logic [4:0] f, input int id);
    @(negedge clk);
    op1_64 = a; op2_64 = b; start64 = 1'b1;
    q64.push_back('{r, f, cyc + 1 + 58, id});
    @(negedge clk);
    start64 = 1'b0;
  endtask

  task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                         input logic [4:0] f, input int id);
    @(negedge clk);
    op1_32 = a; op2_32 = b; start32 = 1'b1;
    q32.push_back('{64'(r), f, cyc + 1 + 29, id});
    @(negedge clk);
    start32 = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 150 && (q64.size() != 0 || q32.size() != 0); i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic run64(input logic [63:0] a, input logic [63:0] b, input logic [63:0] r,
                       input logic [4:0] f, input int id);
    issue64(a, b, r, f, id);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; start64 = 1'b0; start32 = 1'b0;
    op1_64 = '0; op2_64 = '0; op1_32 = '0; op2_32 = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_out64", out64, 64'd0);
    check("rst_flags64", 64'({nan64, ovf64, unf64, zero64, dbz64, done64}), 64'd0);
    check("rst_out32", 64'(out32), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Normal, sign and rounding vectors
    run64(64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, F_NONE, 1);
    repeat (5) @(negedge clk);
    check("hold64", out64, 64'h4008000000000000);
    run64(64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, F_NONE, 2);
    run64(64'hBFF0000000000000, 64'h4008000000000000, 64'hBFD5555555555555, F_NONE, 3);
    run64(64'h4014000000000000, 64'h4008000000000000, 64'h3FFAAAAAAAAAAAAB, F_NONE, 4);
    run64(64'h4008000000000000, 64'h4000000000000000, 64'h3FF8000000000000, F_NONE, 5);

    // Special cases and range limits
    run64(64'h3FF0000000000000, 64'h0000000000000000, 64'h7FF0000000000000, F_DBZ,  6);
    run64(64'h0000000000000000, 64'h0000000000000000, 64'h7FF8000000000000, F_NAN,  7);
    run64(64'h7FE0000000000000, 64'h3FE0000000000000, 64'h7FF0000000000000, F_OVF,  8);
    run64(64'h0010000000000000, 64'h4000000000000000, 64'h0000000000000000, F_UNFZ, 9);
    run64(64'hFFF0000000000000, 64'h4000000000000000, 64'hFFF0000000000000, F_NONE, 10);
    run64(64'h4000000000000000, 64'hFFF0000000000000, 64'h8000000000000000, F_ZERO, 11);
    run64(64'h7FF0000000000000, 64'h7FF0000000000000, 64'h7FF8000000000000, F_NAN,  12);
    run64(64'h7FF8000000000001, 64'h3FF0000000000000, 64'h7FF8000000000000, F_NAN,  13);
    run64(64'h0000000000000000, 64'hC000000000000000, 64'h8000000000000000, F_ZERO, 14);

    // Abort: second start lands 20 edges after the first; only the second completes
    issue64(64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, F_NONE, 15);
    void'(q64.pop_back());
    repeat (18) @(negedge clk);
    run64(64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, F_NONE, 16);

    // binary32
    issue32(32'h40C00000, 32'h40000000, 32'h40400000, F_NONE, 1);
    drain();
    issue32(32'h00000000, 32'h00000000, 32'hFFC00000, F_NAN, 2);
    drain();
    issue32(32'h3F800000, 32'h00000000, 32'h7F800000, F_DBZ, 3);
    drain();
    run64(64'h4014000000000000, 64'h4008000000000000, 64'h3FFAAAAAAAAAAAAB, F_NONE, 17);

    // Reset mid-operation: outputs clear at once and the operation never completes
    issue64(64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, F_NONE, 18);
    void'(q64.pop_back());
    repeat (29) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out64", out64, 64'd0);
    check("midrst_flags64", 64'({nan64, ovf64, unf64, zero64, dbz64, done64}), 64'd0);
    check("midrst_out32", 64'(out32), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (70) @(negedge clk);

    check("pending64", 64'(q64.size()), 64'd0);
    check("pending32", 64'(q32.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/div_float.md
DIV_FLOAT -- requirements
Module: div_float

Interface
REQ-001 SHALL have parameter FLOAT_WIDTH, default 64, operand/result width: 64 gives binary64 (EXP_WIDTH 11, FRACTION_WIDTH 52); any other value gives binary32 (EXP_WIDTH 8, FRACTION_WIDTH 23).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, a request to begin a division.
REQ-005 SHALL have ports op1 and op2, input, FLOAT_WIDTH, dividend and divisor.
REQ-006 SHALL have port out_reg, output, FLOAT_WIDTH, the registered quotient.
REQ-007 SHALL have ports nan_reg, overflow_reg, underflow_reg, zero_reg and div_by_zero_reg, output, 1 each, registered status flags.
REQ-008 SHALL have port done_reg, output, 1, a one-cycle result-valid pulse.

Function
REQ-009 SHALL capture op1 and op2 into internal registers on the edge that samples start=1; operands SHALL be ignored at all other edges.
REQ-010 SHALL implement the states IDLE, SETUP, ITER, NORM and OUT:
- IDLE -> SETUP on start.
- SETUP -> ITER after 1 cycle.
- ITER -> NORM after FRACTION_WIDTH+3 cycles.
- NORM -> OUT after 1 cycle.
- OUT -> IDLE after 1 cycle.
REQ-011 start=1 in any state SHALL abort the current operation, recapture the operands and enter SETUP; no done_reg pulse SHALL be produced for the aborted operation.
REQ-012 SETUP SHALL form the mantissas m1={1,frac1} and m2={1,frac2}, and the signed exponent e = exp1 - exp2 + bias in EXP_WIDTH+2 bits, where bias = 2^(EXP_WIDTH-1)-1.
REQ-013 ITER SHALL run restoring radix-2 division, one quotient bit per cycle, MSB first, giving q[FRACTION_WIDTH+2:0] with q MSB weight 2^0.
REQ-014 NORM SHALL normalise the quotient: if q MSB is 0, q SHALL shift left 1 and e SHALL decrement by 1.
REQ-015 NORM SHALL round by adding the guard bit (the bit below the fraction LSB), ties away from zero; a mantissa carry-out SHALL increment e.
REQ-016 The result sign SHALL be sign1 XOR sign2 for every result, including zero and inf.
REQ-017 An operand with exponent field 0 SHALL be treated as zero (denormals flushed).
REQ-018 The special results SHALL take priority over the normal result, in this order:
- NaN result, 0x7FF8_0000_0000_0000 (64-bit) or 0xFFC0_0000 (32-bit), nan_reg=1: when either operand is NaN, for 0/0, and for inf/inf.
- Signed inf, div_by_zero_reg=1: for nonzero finite/0.
- Signed inf, all flags 0: for inf/finite.
- Signed zero, zero_reg=1: for 0/nonzero and for finite/inf.
- Signed inf, overflow_reg=1: when the final e >= 2^EXP_WIDTH-1.
- Signed zero, underflow_reg=1 and zero_reg=1: when the final e <= 0.
- Otherwise {sign, e[EXP_WIDTH-1:0], rounded fraction}, with all flags 0.
REQ-019 In OUT, out_reg and all flags SHALL load together and done_reg SHALL be 1 for exactly that cycle.
REQ-020 done_reg SHALL rise FRACTION_WIDTH+6 edges after the edge that samples start (58 for 64-bit, 29 for 32-bit).
REQ-021 out_reg and the flags SHALL hold their values until the next OUT state.

Reset
REQ-022 rst_n=0 SHALL immediately force the state to IDLE and set out_reg=0, all flags=0 and done_reg=0, regardless of clk.
REQ-023 Reset during SETUP, ITER or NORM SHALL discard the operation; no done_reg pulse SHALL follow the release of reset until a new start.

Verification
REQ-024 0x4018000000000000 / 0x4000000000000000 (6.0/2.0) -> out_reg=0x4008000000000000, all flags 0, done_reg at edge 58.
REQ-025 0x3FF0000000000000 / 0x4008000000000000 (1/3) -> out_reg=0x3FD5555555555555, and 0xBFF0000000000000 / 0x4008000000000000 -> 0xBFD5555555555555.
REQ-026 Special cases: 1.0/0.0 -> 0x7FF0000000000000 with div_by_zero_reg=1; 0/0 -> 0x7FF8000000000000 with nan_reg=1; 0x7FE0000000000000/0x3FE0000000000000 -> 0x7FF0000000000000 with overflow_reg=1; 0x0010000000000000/0x4000000000000000 -> 0 with underflow_reg=1 and zero_reg=1.
REQ-027 Second start at edge 20 of a division -> exactly one done_reg pulse, 58 edges after the second start, carrying the second operands' result.
REQ-028 rst_n pulsed low at edge 30 -> outputs 0 immediately and no done_reg pulse afterwards; FLOAT_WIDTH=32 with 0x40C00000/0x40000000 -> 0x40400000 at edge 29.
